// File: rtl/fetch_unit_v2.sv
`default_nettype none
// ============================================================================
// fetch_unit_v2 : single-outstanding instruction fetcher with prefetch queue
// Revision      : 1.0
// ============================================================================
module fetch_unit_v2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam int INC   = DATA_W / 8;
  localparam int LSB   = $clog2(INC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INC_A      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LSB;
  localparam logic [PTR_W:0]    CNT_FULL   = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PTR_W:0]      count_q;
  logic [PTR_W-1:0]    rd_q, wr_q;
  logic [DATA_W-1:0]   qdata_q [DEPTH];
  logic [ADDR_W-1:0]   qpc_q   [DEPTH];

  logic                push, pop, flush;
  logic [PTR_W:0]      cnt_after;
  logic [ADDR_W-1:0]   redir_al;

  assign redir_al  = redirect_pc & ALIGN_MASK;
  assign pop       = instr_valid && instr_ready && !redirect_valid;
  assign cnt_after = count_q + (PTR_W+1)'(1) - (PTR_W+1)'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redir_al;
          state_d = ST_WAIT;
        end else if (count_q < CNT_FULL) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redir_al;
          // DISCARD keeps presenting the abandoned address until memory answers
          addr_d  = pc_q;
          state_d = imem_ack ? ST_WAIT : ST_DISCARD;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + INC_A;
          state_d = (cnt_after < CNT_FULL) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redir_al;
        end
        if (imem_ack) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qdata_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if (flush) begin
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        if (push) begin
          qdata_q[wr_q] <= imem_rdata;
          qpc_q[wr_q]   <= pc_q;
          wr_q          <= wr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_q <= rd_q + PTR_W'(1);
        end
        count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  assign imem_req    = (state_q != ST_IDLE);
  assign imem_addr   = (state_q == ST_DISCARD) ? addr_q : pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_data  = qdata_q[rd_q];
  assign instr_pc    = qpc_q[rd_q];
  assign pc          = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_v2.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit_v2 : directed self-checking bench for fetch_unit_v2
// Revision         : 1.0
// ============================================================================
module tb_fetch_unit_v2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;
  bit mem_en = 1'b0;
  int lat    = 1;
  int mcnt   = 0;

  fetch_unit_v2 #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // One clock; the memory responder decides its strobe for the coming edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (mem_en) begin
      if (imem_req) begin
        if (mcnt == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mdata(imem_addr);
          mcnt       = 0;
        end else begin
          imem_ack = 1'b0;
          mcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        mcnt     = 0;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0;
    instr_ready = 1'b0; mem_en = 1'b0; mcnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
    total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", instr_data); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_ipc got=%h want=0", instr_pc); end
    reset = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_first_addr got=%h want=0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    int cycs[$];
    apply_reset();
    instr_ready = 1'b1; mem_en = 1'b1; lat = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (instr_valid) begin
        pcs.push_back(instr_pc);
        cycs.push_back(c);
        total++; if (instr_data !== mdata(instr_pc)) begin bad++; $display("FAIL stream_data pc=%h got=%h want=%h", instr_pc, instr_data, mdata(instr_pc)); end
      end
    end
    total++; if (pcs.size() < 4) begin bad++; $display("FAIL stream_count got=%0d want>=4", pcs.size()); end
    if (pcs.size() >= 4) begin
      total++; if (cycs[0] != 2) begin bad++; $display("FAIL stream_first_cycle got=%0d want=2", cycs[0]); end
      for (int i = 0; i < 4; i++) begin
        total++; if (pcs[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%h want=%h", i, pcs[i], 32'(4 * i)); end
      end
      for (int i = 1; i < 4; i++) begin
        total++; if (cycs[i] - cycs[i-1] != 2) begin bad++; $display("FAIL stream_gap%0d got=%0d want=2", i, cycs[i] - cycs[i-1]); end
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_full();
    int acks;
    logic [31:0] first_addr;
    bit seen;
    apply_reset();
    instr_ready = 1'b0; mem_en = 1'b1; lat = 1;
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (imem_ack) acks++;
    end
    total++; if (acks != 4) begin bad++; $display("FAIL full_pushes got=%0d want=4", acks); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b want=0", imem_req); end
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL full_pc got=%h want=10", pc); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL full_head got=%h want=0", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL full_pop_head got=%h want=4", instr_pc); end
    acks = 0; seen = 1'b0; first_addr = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (imem_req && !seen) begin seen = 1'b1; first_addr = imem_addr; end
      if (imem_ack) acks++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL refill_acks got=%0d want=1", acks); end
    total++; if (first_addr !== 32'h10) begin bad++; $display("FAIL refill_addr got=%h want=10", first_addr); end
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL refill_pc got=%h want=14", pc); end
    mem_en = 1'b0; imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL idle_redir_valid got=%b want=0", instr_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL idle_redir_req got=%b/%h want=1/40", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL disc_hold got=%b/%h want=1/0", imem_req, imem_addr); end
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL disc_pc got=%h want=100", pc); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL disc_drop got=%b want=0", instr_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL disc_newreq got=%b/%h want=1/100", imem_req, imem_addr); end
    mem_en = 1'b1; lat = 1; mcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (instr_valid) break;
      tick();
    end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL disc_first_valid got=%b want=1 (timeout)", instr_valid); end
    total++; if (instr_pc !== 32'h100) begin bad++; $display("FAIL disc_first_pc got=%h want=100", instr_pc); end
    total++; if (instr_data !== mdata(32'h100)) begin bad++; $display("FAIL disc_first_data got=%h want=%h", instr_data, mdata(32'h100)); end
    mem_en = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_redirect_ack_pop();
    apply_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h11;
    tick();
    imem_ack = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL rap_pre got=%b/%h want=1/0", instr_valid, instr_pc); end
    imem_ack = 1'b1; imem_rdata = 32'h22; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rap_flush got=%b want=0", instr_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL rap_addr got=%b/%h want=1/200", imem_req, imem_addr); end
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL rap_pc got=%h want=200", pc); end
    imem_ack = 1'b1; imem_rdata = 32'h33;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'h200 || instr_data !== 32'h33) begin bad++; $display("FAIL rap_next got=%h/%h want=200/33", instr_pc, instr_data); end
  endtask

  task automatic test_wrap();
    apply_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h99;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%b/%h want=0/fffffffc", instr_valid, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h44;
    tick();
    imem_ack = 1'b0;
    total++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h/%h want=0/0", pc, imem_addr); end
    total++; if (instr_pc !== 32'hFFFF_FFFC || instr_data !== 32'h44) begin bad++; $display("FAIL wrap_head got=%h/%h want=fffffffc/44", instr_pc, instr_data); end
  endtask

  task automatic test_reset_discard();
    apply_reset();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h99;
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL rd_disc got=%b/%h want=1/4", imem_req, imem_addr); end
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rd_async_req got=%b/%h want=0/0", imem_req, imem_addr); end
    total++; if (pc !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rd_async_pc got=%h/%b want=0/0", pc, instr_valid); end
    total++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL rd_async_q got=%h/%h want=0/0", instr_data, instr_pc); end
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h77;
    tick();
    imem_ack = 1'b0;
    total++; if (pc !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rd_ack_ignored got=%h/%b want=0/0", pc, instr_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rd_wait got=%b/%h want=1/0", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h55;
    tick();
    imem_ack = 1'b0;
    total++; if (instr_pc !== 32'h0 || instr_data !== 32'h55 || pc !== 32'h4) begin bad++; $display("FAIL rd_first got=%h/%h/%h want=0/55/4", instr_pc, instr_data, pc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit_v2.md
FETCH_UNIT_V2 -- requirements
Module: fetch_unit_v2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: fetch address / PC width.
REQ-002 SHALL have parameter DATA_W, default 32: instruction width, multiple of 8; INC = DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 4: prefetch queue entries, power of 2, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0: fetch address after reset, INC-aligned.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  out  ADDR_W  fetch address; stable while imem_req high.
REQ-009 SHALL have port imem_ack  in  1  memory response strobe; imem_rdata valid only in this cycle.
REQ-010 SHALL have port imem_rdata  in  DATA_W  fetched instruction.
REQ-011 SHALL have port redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-012 SHALL have port redirect_pc  in  ADDR_W  redirect target.
REQ-013 SHALL have port instr_valid  out  1  queue head valid.
REQ-014 SHALL have port instr_data  out  DATA_W  queue head instruction.
REQ-015 SHALL have port instr_pc  out  ADDR_W  address of queue head instruction.
REQ-016 SHALL have port instr_ready  in  1  consumer accepts head.
REQ-017 SHALL have port pc  out  ADDR_W  current fetch PC (next address to request).

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, DISCARD; at most one memory request outstanding.
REQ-019 IDLE: SHALL go to WAIT next cycle when queue count < DEPTH, else stay; imem_req = 0; imem_ack ignored.
REQ-020 WAIT: SHALL drive imem_req = 1, imem_addr = pc, held until imem_ack.
REQ-021 WAIT with imem_ack: SHALL push {pc, imem_rdata} into queue, pc <= pc + INC (mod 2^ADDR_W); next state WAIT if count after push < DEPTH, else IDLE.
REQ-022 Pop SHALL occur when instr_valid && instr_ready; instr_valid = (count != 0) with instr_data/instr_pc from head, registered outputs.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Push when full SHALL be impossible by construction (no request issued at count == DEPTH); pop when empty SHALL be ignored.
REQ-025 redirect_valid SHALL flush the queue (count = 0, instr_valid = 0 next cycle) and load pc <= redirect_pc with low log2(INC) bits forced to 0.
REQ-026 Redirect in WAIT without same-cycle ack SHALL go to DISCARD; DISCARD holds imem_req = 1 with old address until imem_ack, drops imem_rdata, then goes to WAIT at the new pc.
REQ-027 Redirect coincident with imem_ack SHALL drop the returned data and go to WAIT at the new pc.
REQ-028 Redirect coincident with pop SHALL take priority; pop has no effect.
REQ-029 Redirect in DISCARD SHALL update pc again and remain in DISCARD (or go to WAIT if ack same cycle, data dropped).
REQ-030 Redirect in IDLE SHALL flush and load pc; next state WAIT.
REQ-031 Steady-state throughput SHALL be one instruction per (memory latency + 1) cycles; reset release to first imem_req = 1 cycle.

Reset
REQ-032 reset high SHALL immediately force state IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_req = 0, count = 0, pointers = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
REQ-033 Reset mid-request SHALL abandon the request; instruction memory shares the same reset, and any imem_ack seen in IDLE SHALL be ignored.

Verification
REQ-034 Reset release, memory acks 1 cycle after each req, instr_ready = 1 -> instr_pc sequence 0x0, 0x4, 0x8, 0xC with matching data, no gaps other than latency.
REQ-035 instr_ready = 0, DEPTH = 4 -> exactly 4 pushes (0x0..0xC), imem_req drops, pc = 0x10; one pop -> one new request at 0x10.
REQ-036 Redirect to 0x100 while in WAIT, ack 2 cycles later -> stale data discarded, queue empty, next request addr 0x100, first instr_pc = 0x100.
REQ-037 Redirect to 0x203 coincident with ack and pop -> data dropped, pop ignored, next imem_addr = 0x200.
REQ-038 pc = 0xFFFFFFFC fetched -> next pc = 0x00000000 (wrap).
REQ-039 Assert reset during DISCARD -> all outputs at reset values same cycle; ack after release ignored until WAIT at RESET_PC.
